// File: rtl/bcd_ascii_sequencer.sv
// Streams a packed BCD word out as ASCII characters, most-significant digit first.
// Optional leading-zero suppression is enabled by defining BCD_SEQ_LZS_EN.

module BCD4bit_ASCII8bit #(
    parameter int N = 4,
    parameter int M = 8
) (
    input  logic [N-1:0] A,
    output logic [M-1:0] B,
    output logic         C
);

    assign C = (A > N'(9));
    assign B = M'(8'h30) + M'(A);

endmodule

module bcd_ascii_sequencer #(
    parameter int N      = 4,
    parameter int M      = 8,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [M-1:0]          out_char,
    output logic                  out_last,
    output logic                  out_err
);

    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [N*DIGITS-1:0]    shadow_r;
    logic                   out_valid_r;
    logic [M-1:0]           out_char_r;
    logic                   out_last_r;
    logic                   out_err_r;

    logic [CW-1:0]          start_s;
    logic [CW-1:0]          next_idx_s;
    logic [CW-1:0]          sel_idx_s;
    logic [N*DIGITS-1:0]    src_word_s;
    logic [N-1:0]           digit_s;
    logic [M-1:0]           conv_b_s;
    logic                   conv_c_s;
    logic [M-1:0]           char_s;

    // Index of the first digit to emit for the word presented on in_bcd.
    always_comb begin
        start_s = CW'(0);
`ifdef BCD_SEQ_LZS_EN
        // Ascending scan: the last non-zero hit is the most-significant one.
        for (int i = 0; i < DIGITS; i++) begin
            if (in_bcd[i*N +: N] != N'(0)) begin
                start_s = CW'(i);
            end else begin
                start_s = start_s;
            end
        end
`else
        start_s = CW'(DIGITS - 1);
`endif
    end

    // In IDLE the first character comes straight from in_bcd; afterwards from the shadow copy.
    always_comb begin
        next_idx_s = cnt_r - CW'(1);
        if (state_r == IDLE) begin
            sel_idx_s  = start_s;
            src_word_s = in_bcd;
        end else begin
            sel_idx_s  = next_idx_s;
            src_word_s = shadow_r;
        end
    end

    // Select the digit to translate.
    always_comb begin
        digit_s = N'(0);
        for (int i = 0; i < DIGITS; i++) begin
            if (CW'(i) == sel_idx_s) begin
                digit_s = src_word_s[i*N +: N];
            end else begin
                digit_s = digit_s;
            end
        end
    end

    BCD4bit_ASCII8bit #(
        .N (N),
        .M (M)
    ) u_conv (
        .A (digit_s),
        .B (conv_b_s),
        .C (conv_c_s)
    );

    // Invalid digits are replaced by '?' but still flow through the word.
    always_comb begin
        if (conv_c_s) begin
            char_s = M'(8'h3F);
        end else begin
            char_s = conv_b_s;
        end
    end

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign out_last  = out_last_r;
    assign out_err   = out_err_r;

    // Sequencer FSM with registered character outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= CW'(0);
            shadow_r    <= '0;
            out_valid_r <= 1'b0;
            out_char_r  <= M'(8'h00);
            out_last_r  <= 1'b0;
            out_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        shadow_r    <= in_bcd;
                        cnt_r       <= start_s;
                        out_valid_r <= 1'b1;
                        out_char_r  <= char_s;
                        out_last_r  <= (start_s == CW'(0));
                        out_err_r   <= conv_c_s;
                        state_r     <= EMIT;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            state_r     <= IDLE;
                        end else begin
                            cnt_r       <= next_idx_s;
                            out_char_r  <= char_s;
                            out_last_r  <= (next_idx_s == CW'(0));
                            out_err_r   <= conv_c_s;
                        end
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_ascii_sequencer.sv
// Self-checking bench for bcd_ascii_sequencer: table vectors, hand sequences, random words vs model.
// Expectations follow BCD_SEQ_LZS_EN when the macro is defined.

module tb_bcd_ascii_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_char;
    logic        out_last;
    logic        out_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        logic [15:0]     word;
        int              len;
        logic [3:0][8:0] ch;
        int              mode;
        bit              keep;
    } vec_t;

    vec_t vecs[5];

    bcd_ascii_sequencer #(.N(4), .M(8), .DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .out_last  (out_last),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: digit list MSD first, optional leading-zero strip, map to ASCII or '?'.
    function automatic void model(input logic [15:0] w);
        int start;
        logic [3:0] d;
        exp_q.delete();
        start = 3;
`ifdef BCD_SEQ_LZS_EN
        start = 0;
        for (int i = 3; i >= 0; i--) begin
            if (w[i*4 +: 4] != 4'h0) begin
                start = i;
                break;
            end
        end
`endif
        for (int i = start; i >= 0; i--) begin
            d = w[i*4 +: 4];
            if (d > 4'd9) exp_q.push_back({1'b1, 8'h3F});
            else exp_q.push_back({1'b0, 8'h30 + {4'h0, d}});
        end
    endfunction

    function automatic vec_t mk(input logic [15:0] w, input int len,
                                input logic [8:0] c0, input logic [8:0] c1,
                                input logic [8:0] c2, input logic [8:0] c3,
                                input int mode, input bit keep);
        vec_t v;
        v.word = w;
        v.len  = len;
        v.ch[0] = c0;
        v.ch[1] = c1;
        v.ch[2] = c2;
        v.ch[3] = c3;
        v.mode = mode;
        v.keep = keep;
        return v;
    endfunction

    // mode 0: always ready, 1: random ready, 2: fixed stall pattern 0,1,0,0,1,1,0,1
    task automatic send_word(input logic [15:0] w, input int mode, input bit keep);
        int idx;
        int cyc;
        int p;
        logic r;
        logic [7:0] pat;
        pat = 8'b1011_0010;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_out_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_bcd   = w;
        step();
        if (!keep) in_valid = 1'b0;
        idx = 0;
        cyc = 0;
        p   = 0;
        while (idx < exp_q.size() && cyc < 200) begin
            check("emit_valid", {31'd0, out_valid}, 32'd1);
            check("emit_in_ready", {31'd0, in_ready}, 32'd0);
            check("char_err", {23'd0, out_err, out_char}, {23'd0, exp_q[idx]});
            check("last", {31'd0, out_last}, (idx == exp_q.size() - 1) ? 32'd1 : 32'd0);
            case (mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    r = pat[p % 8];
                    p++;
                end
            endcase
            out_ready = r;
            step();
            if (r) idx++;
            cyc++;
        end
        if (idx < exp_q.size()) check("emit_timeout", idx, exp_q.size());
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        check("done_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;

        vecs[0] = mk(16'h1234, 4, 9'h031, 9'h032, 9'h033, 9'h034, 0, 1'b0);
`ifdef BCD_SEQ_LZS_EN
        vecs[1] = mk(16'h0042, 2, 9'h034, 9'h032, 9'h000, 9'h000, 0, 1'b0);
        vecs[2] = mk(16'h0000, 1, 9'h030, 9'h000, 9'h000, 9'h000, 0, 1'b0);
`else
        vecs[1] = mk(16'h0042, 4, 9'h030, 9'h030, 9'h034, 9'h032, 0, 1'b0);
        vecs[2] = mk(16'h0000, 4, 9'h030, 9'h030, 9'h030, 9'h030, 0, 1'b0);
`endif
        vecs[3] = mk(16'h1A05, 4, 9'h031, 9'h13F, 9'h030, 9'h035, 0, 1'b0);
        vecs[4] = mk(16'h9876, 4, 9'h039, 9'h038, 9'h037, 9'h036, 2, 1'b1);

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_bcd    = 16'h0000;
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_char", {24'd0, out_char}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            for (int k = 0; k < vecs[v].len; k++) exp_q.push_back(vecs[v].ch[k]);
            send_word(vecs[v].word, vecs[v].mode, vecs[v].keep);
        end

        // Reset after the second character of 1234: remaining characters are dropped.
        in_valid  = 1'b1;
        in_bcd    = 16'h1234;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_char0", {23'd0, out_err, out_char}, 32'h031);
        step();
        check("mid_char1", {23'd0, out_err, out_char}, 32'h032);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_char", {24'd0, out_char}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_rst_quiet", {31'd0, out_valid}, 32'd0);
        end
        out_ready = 1'b0;
        model(16'h0005);
        send_word(16'h0005, 0, 1'b0);

        // Reset coinciding with an accept: the word must not be taken.
        in_valid = 1'b1;
        in_bcd   = 16'h4321;
        rst      = 1'b1;
        step();
        in_valid = 1'b0;
        rst      = 1'b0;
        check("rst_vs_accept", {31'd0, out_valid}, 32'd0);
        step();
        check("rst_vs_accept_late", {31'd0, out_valid}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            case ($urandom_range(0, 3))
                0: w = w & 16'h00FF;
                1: w = w & 16'h0FFF;
                2: w = w & 16'h000F;
                default: w = w;
            endcase
            model(w);
            send_word(w, 1, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
